// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and constants for the LSU memory-access stage.
// Optional feature macro used by this slice: LSU_MISALIGN_TRAP_EN.
package lsu_mem_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned CSR_WEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Fields that ride along with the instruction to write-back untouched
    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [REG_AW-1:0]    rd;
        logic                 r_wen;
        logic [CSR_WEN_W-1:0] csr_wen;
        logic [XLEN-1:0]      csrs;
        logic                 branch_flag;
        logic                 jump_flag;
    } wb_side_t;

    // Access size lives in funct3[1:0]: 00 byte, 01 half, 1x word
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == 2'b01) begin
            mis = a[0];
        end else if (f3[1]) begin
            mis = (a != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store data/strobe placement and load extract/extend.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata_c,
    output logic [3:0]  st_wstrb_c,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the datum across lanes, strobe the addressed lane(s)
    always_comb begin
        st_wdata_c = st_data;
        st_wstrb_c = 4'b1111;
        case ({1'b0, st_funct3[1:0]})
            F3_SB: begin
                st_wdata_c = {4{st_data[7:0]}};
                st_wstrb_c = 4'b0001 << st_addr_lo;
            end
            F3_SH: begin
                st_wdata_c = {2{st_data[15:0]}};
                st_wstrb_c = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW:   st_wstrb_c = 4'b1111;
            default: st_wstrb_c = 4'b1111;
        endcase
    end

    // Load: pick the addressed lane and extend; unknown encodings read the word
    always_comb begin
        ld_byte   = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half   = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data_c = ld_rdata;
        case (ld_funct3)
            F3_LB:   ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data_c = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data_c = {24'b0, ld_byte};
            F3_LHU:  ld_data_c = {16'b0, ld_half};
            F3_LW:   ld_data_c = ld_rdata;
            default: ld_data_c = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: latches the execute bundle, runs the data-memory
// request/ack handshake, and presents the write-back bundle.
// Optional: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses
// instead of issuing them aligned-down.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   pc,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] rs2_value,
    input  logic [2:0]    funct3,
    input  logic          mem_wen,
    input  logic          mem_ren,
    input  logic [4:0]    rd,
    input  logic          R_wen,
    input  logic [3:0]    csr_wen,
    input  logic [31:0]   csrs,
    input  logic          branch_flag,
    input  logic          jump_flag,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] wb_result,
    output logic [31:0]   wb_pc,
    output logic [4:0]    wb_rd,
    output logic          wb_R_wen,
    output logic [3:0]    wb_csr_wen,
    output logic [31:0]   wb_csrs,
    output logic          wb_branch_flag,
    output logic          wb_jump_flag,
    output logic          misalign
);

    lsu_state_t  state_q;
    wb_side_t    side_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_addr_lo_q;

    logic        accept_c;
    logic        mem_op_c;
    logic        trap_c;
    logic [31:0] st_wdata_c;
    logic [3:0]  st_wstrb_c;
    logic [31:0] ld_data_c;

    // Accept from IDLE, or straight out of DONE when write-back drains this cycle
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_c = in_valid && in_ready;
    assign mem_op_c = mem_ren || mem_wen;

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned half/word accesses short-circuit to DONE with a flag
    assign trap_c = mem_op_c && is_misaligned(funct3, ex_result[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_addr_lo (ex_result[1:0]),
        .st_data    (rs2_value),
        .st_wdata_c (st_wdata_c),
        .st_wstrb_c (st_wstrb_c),
        .ld_funct3  (ld_funct3_q),
        .ld_addr_lo (ld_addr_lo_q),
        .ld_rdata   (dmem_rdata),
        .ld_data_c  (ld_data_c)
    );

    assign wb_pc          = side_q.pc;
    assign wb_rd          = side_q.rd;
    assign wb_R_wen       = side_q.r_wen;
    assign wb_csr_wen     = side_q.csr_wen;
    assign wb_csrs        = side_q.csrs;
    assign wb_branch_flag = side_q.branch_flag;
    assign wb_jump_flag   = side_q.jump_flag;

    // Stage FSM with all bundle, memory-port and write-back registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            side_q       <= '0;
            ld_funct3_q  <= 3'b000;
            ld_addr_lo_q <= 2'b00;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= 4'b0000;
            out_valid    <= 1'b0;
            wb_result    <= '0;
            misalign     <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                        // Stores keep ex_result, loaded at accept time
                        if (!dmem_we) begin
                            wb_result <= ld_data_c;
                        end
                    end
                end
                default: begin
                    if ((state_q == ST_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        misalign  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                    if (accept_c) begin
                        side_q <= '{pc:          pc,
                                    rd:          rd,
                                    r_wen:       R_wen && !trap_c,
                                    csr_wen:     csr_wen,
                                    csrs:        csrs,
                                    branch_flag: branch_flag,
                                    jump_flag:   jump_flag};
                        wb_result <= ex_result;
                        misalign  <= trap_c;
                        if (mem_op_c && !trap_c) begin
                            ld_funct3_q  <= funct3;
                            ld_addr_lo_q <= ex_result[1:0];
                            dmem_we      <= mem_wen;
                            dmem_addr    <= AW'({ex_result[31:2], 2'b00});
                            dmem_wdata   <= st_wdata_c;
                            dmem_wstrb   <= mem_wen ? st_wstrb_c : 4'b0000;
                            dmem_req     <= 1'b1;
                            out_valid    <= 1'b0;
                            state_q      <= ST_ACCESS;
                        end else begin
                            out_valid <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
